// File: rtl/nabp_image_ram_writer_if.sv
// nabp_image_ram_writer_if
//   Bundles the three streams the image-RAM writer talks to:
//     - PE chain value stream (pe_valid / pe_ready / pe_data)
//     - image addresser control (ir_kick / ir_kick_ack / ir_enable / ir_addr)
//     - image RAM read and write ports (ram_rd_* / ram_wr_*)
//   master : the writer itself
//   slave  : the environment (PE chain, addresser, RAM)
//
// Handshake semantics: a PE beat transfers on a rising clock edge where
// pe_valid && pe_ready are both high. pe_data must be stable while pe_valid
// is high. ir_kick is held high until the edge on which ir_kick_ack is seen.
// ir_enable pulses once per transferred beat. ram_rd_data is valid the cycle
// after ram_rd_en.
`timescale 1ns/1ps
interface nabp_image_ram_writer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic                  pe_valid;
  logic                  pe_ready;
  logic [DATA_WIDTH-1:0] pe_data;
  logic                  ir_kick;
  logic                  ir_kick_ack;
  logic                  ir_enable;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;

  modport master (
    input  pe_valid, pe_data, ir_kick_ack, ir_addr, ram_rd_data,
    output pe_ready, ir_kick, ir_enable, ram_rd_en, ram_rd_addr,
           ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    output pe_valid, pe_data, ir_kick_ack, ir_addr, ram_rd_data,
    input  pe_ready, ir_kick, ir_enable, ram_rd_en, ram_rd_addr,
           ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/nabp_image_ram_writer.sv
// nabp_image_ram_writer
//   Kicks the image addresser, then consumes one back-projected PE value per
//   beat and accumulates (or overwrites) it into the image RAM through a
//   one-stage read-modify-write pipeline with write-to-read forwarding.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             one-cycle pulse that begins a pass (IDLE only)
//   accumulate        sampled with start: 1 = add into RAM, 0 = overwrite
//   busy              high while a pass is in progress
//   done              one-cycle pulse at the end of a pass
//   bus               PE stream, addresser control and RAM ports
//   dbg_state         current FSM state (IDLE=0, KICK=1, STREAM=2, DRAIN=3)
//   dbg_fwd_hit       write data is using the forwarded previous write
`timescale 1ns/1ps
module nabp_image_ram_writer #(
  parameter int IMAGE_SIZE     = 128,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 16,
  parameter int BEATS_PER_PASS = 32768
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          accumulate,
  output logic                          busy,
  output logic                          done,
  nabp_image_ram_writer_if.master       bus,
  output logic [1:0]                    dbg_state,
  output logic                          dbg_fwd_hit
);
  // One pass covers every pixel twice, so the counter spans 2*IMAGE_SIZE^2.
  localparam int CW = $clog2(2 * IMAGE_SIZE * IMAGE_SIZE);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_PASS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KICK   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  acc_q;
  logic [CW-1:0]         beat_q;

  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  logic                  fwd_valid_q;
  logic [ADDR_WIDTH-1:0] fwd_addr_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  logic                  accept;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] sat_val;
  logic [DATA_WIDTH-1:0] wr_data;

  assign accept = bus.pe_valid && (state_q == STREAM);

  assign bus.pe_ready   = (state_q == STREAM);
  assign bus.ir_kick    = (state_q == KICK);
  assign bus.ir_enable  = accept;
  assign bus.ram_rd_en  = accept;
  assign bus.ram_rd_addr = bus.ir_addr;

  // The RAM returns pre-write data when a read and a write to the same
  // address share a cycle, so the last write is replayed from fwd_*.
  assign fwd_hit = s1_valid_q && fwd_valid_q && (fwd_addr_q == s1_addr_q);
  assign old_val = fwd_hit ? fwd_data_q : bus.ram_rd_data;
  assign sum     = {old_val[DATA_WIDTH-1], old_val} + {s1_data_q[DATA_WIDTH-1], s1_data_q};

  // Overflow when the two top bits of the widened sum disagree; the extra
  // top bit then carries the true sign.
  always_comb begin
    sat_val = sum[DATA_WIDTH-1:0];
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat_val = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  assign wr_data         = acc_q ? sat_val : s1_data_q;
  assign bus.ram_wr_en   = s1_valid_q;
  assign bus.ram_wr_addr = s1_addr_q;
  assign bus.ram_wr_data = wr_data;

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DRAIN) && !s1_valid_q;
  assign dbg_state   = state_q;
  assign dbg_fwd_hit = fwd_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= accumulate;
            beat_q  <= '0;
            state_q <= KICK;
          end
        end
        KICK: begin
          if (bus.ir_kick_ack) state_q <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pipeline stage and forwarding register; reset drops any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= bus.ir_addr;
        s1_data_q <= bus.pe_data;
      end
      fwd_valid_q <= s1_valid_q;
      fwd_addr_q  <= s1_addr_q;
      fwd_data_q  <= wr_data;
    end
  end
endmodule

// File: tb/tb_nabp_image_ram_writer.sv
`timescale 1ns/1ps
module tb_nabp_image_ram_writer;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NB = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic start, accumulate, busy, done, dbg_fwd_hit;
  logic [1:0] dbg_state;

  nabp_image_ram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  nabp_image_ram_writer #(
    .IMAGE_SIZE(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS_PER_PASS(NB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .accumulate(accumulate),
    .busy(busy), .done(done), .bus(bus),
    .dbg_state(dbg_state), .dbg_fwd_hit(dbg_fwd_hit)
  );

  // ---------------- environment models ----------------
  logic [AW-1:0] addr_tab [NB];
  logic [DW-1:0] data_tab [NB];
  int idx;
  int cyc_cnt = 0;

  // Addresser: restarts on the kick handshake, advances on ir_enable.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) idx <= 0;
    else if (bus.ir_kick && bus.ir_kick_ack) idx <= 0;
    else if (bus.ir_enable) idx <= idx + 1;
  end
  assign bus.ir_addr = addr_tab[idx & 31];
  assign bus.pe_data = data_tab[idx & 31];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural RAM: 1-cycle read, read-during-write returns old data.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] load_img [16];
  logic load_en;
  always @(posedge clk) begin
    if (load_en) mem <= load_img;
    else begin
      if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
      if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] sat8(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  task automatic build_expect(input logic acc, input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      a = addr_tab[i];
      v = acc ? sat8(model_mem[a], data_tab[i]) : data_tab[i];
      model_mem[a] = v;
      exp_q.push_back({a, v});
    end
  endtask

  int kick_cyc, pr_in_kick, en_cnt, wr_cnt, last_wr_cyc;
  logic [DW-1:0] wr_log [64];
  logic fwd_log [64];

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (bus.ir_kick) begin
      kick_cyc++;
      if (bus.pe_ready) pr_in_kick++;
    end
    if (bus.ir_enable) en_cnt++;
    if (bus.ir_enable || bus.ram_rd_en || (bus.pe_valid && bus.pe_ready)) begin
      check("ir_enable", bus.ir_enable, bus.pe_valid && bus.pe_ready);
      check("rd_en", bus.ram_rd_en, bus.pe_valid && bus.pe_ready);
      check("rd_addr", bus.ram_rd_addr, bus.ir_addr);
    end
    if (bus.ram_wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.ram_wr_addr, e[AW+DW-1:DW]);
        check("wr_data", bus.ram_wr_data, e[DW-1:0]);
      end
      wr_log[wr_cnt & 63] = bus.ram_wr_data;
      fwd_log[wr_cnt & 63] = dbg_fwd_hit;
      last_wr_cyc = cyc_cnt;
      wr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [DW-1:0] fill, input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    for (int a = 0; a < 16; a++) load_img[a] = fill;
    load_img[0] = v0;
    load_img[1] = v1;
    model_mem = load_img;
    @(posedge clk); #1 load_en = 1'b1;
    @(posedge clk); #1 load_en = 1'b0;
  endtask

  task automatic run_pass(input logic acc, input int ack_delay, input bit bubbles,
                          input int limit, input bit poke_start);
    kick_cyc = 0; pr_in_kick = 0; en_cnt = 0; wr_cnt = 0;
    @(posedge clk); #1 start = 1'b1; accumulate = acc;
    @(posedge clk); #1 start = 1'b0; accumulate = ~acc;
    for (int d = 0; d < ack_delay; d++) begin @(posedge clk); #1; end
    bus.ir_kick_ack = 1'b1;
    @(posedge clk); #1 bus.ir_kick_ack = 1'b0;
    for (int c = 0; c < 400 && idx < limit; c++) begin
      bus.pe_valid = bubbles ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      start = poke_start && (c == 2);
      @(posedge clk); #1;
    end
    bus.pe_valid = 1'b0;
    start = 1'b0;
    accumulate = 1'b0;
    check("accept_count", idx, limit);
  endtask

  task automatic wait_done(input int nwr);
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", done, 1);
    check("done_lag", cyc_cnt - last_wr_cyc, 1);
    check("no_wr_at_done", bus.ram_wr_en, 0);
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_after_done", busy, 0);
    check("wr_count", wr_cnt, nwr);
    check("en_count", en_cnt, nwr);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < 16; a++) check(tag, mem[a], model_mem[a]);
  endtask

  task automatic outputs_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pe_ready"}, bus.pe_ready, 0);
    check({tag, "_ir_kick"}, bus.ir_kick, 0);
    check({tag, "_ir_enable"}, bus.ir_enable, 0);
    check({tag, "_rd_en"}, bus.ram_rd_en, 0);
    check({tag, "_wr_en"}, bus.ram_wr_en, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; accumulate = 1'b0; load_en = 1'b0;
    bus.pe_valid = 1'b0; bus.ir_kick_ack = 1'b0;
    for (int a = 0; a < 16; a++) begin load_img[a] = '0; model_mem[a] = '0; end
    #3;
    outputs_idle("reset");
    check("reset_state", dbg_state, 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    preload(8'd0, 8'd0, 8'd0);

    // Spurious ack in IDLE must not start anything.
    bus.ir_kick_ack = 1'b1;
    @(negedge clk); @(negedge clk);
    check("spurious_ack_state", dbg_state, 0);
    check("spurious_ack_kick", bus.ir_kick, 0);
    #1 bus.ir_kick_ack = 1'b0;

    // Overwrite pass, sequential addresses, data = beat number.
    for (int k = 0; k < NB; k++) begin addr_tab[k] = AW'(k % 16); data_tab[k] = DW'(k); end
    build_expect(1'b0, NB);
    run_pass(1'b0, 2, 1'b0, NB, 1'b0);
    wait_done(NB);
    check("ow_kick_cycles", kick_cyc, 3);
    check_ram("ow_ram");
    check("ow_mem5", mem[5], 8'd21);
    check("ow_mem15", mem[15], 8'd31);

    // Accumulate with forwarding and saturation.
    preload(8'd5, 8'd120, 8'h88);
    for (int k = 0; k < NB; k++) begin addr_tab[k] = AW'(8 + k % 8); data_tab[k] = 8'd0; end
    addr_tab[0] = 4'd3; data_tab[0] = 8'd1;
    addr_tab[1] = 4'd3; data_tab[1] = 8'd2;
    addr_tab[2] = 4'd3; data_tab[2] = 8'd3;
    addr_tab[3] = 4'd0; data_tab[3] = 8'd20;
    addr_tab[4] = 4'd1; data_tab[4] = 8'hEC;
    build_expect(1'b1, NB);
    run_pass(1'b1, 0, 1'b0, NB, 1'b0);
    wait_done(NB);
    check("acc_wr0", wr_log[0], 8'd6);
    check("acc_wr1", wr_log[1], 8'd8);
    check("acc_wr2", wr_log[2], 8'd11);
    check("fwd_beat1", fwd_log[0], 0);
    check("fwd_beat2", fwd_log[1], 1);
    check("fwd_beat3", fwd_log[2], 1);
    check("fwd_beat4", fwd_log[3], 0);
    check("sat_pos", mem[0], 8'd127);
    check("sat_neg", mem[1], 8'h80);
    check("acc_mem3", mem[3], 8'd11);
    check_ram("acc_ram");

    // Bubbles, delayed ack, start poked during STREAM.
    for (int k = 0; k < NB; k++) begin addr_tab[k] = AW'(k % 16); data_tab[k] = DW'(50 + k); end
    build_expect(1'b0, NB);
    run_pass(1'b0, 5, 1'b1, NB, 1'b1);
    wait_done(NB);
    check("bub_kick_cycles", kick_cyc, 6);
    check("bub_ready_in_kick", pr_in_kick, 0);
    repeat (3) @(negedge clk);
    check("bub_start_ignored", busy, 0);
    check("bub_mem9", mem[9], 8'd75);
    check_ram("bub_ram");

    // Reset mid-pass after 10 accepts: the 10th beat's write is dropped.
    for (int k = 0; k < NB; k++) begin addr_tab[k] = AW'(k % 16); data_tab[k] = DW'(100 + k); end
    build_expect(1'b0, 9);
    run_pass(1'b0, 1, 1'b0, 10, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    outputs_idle("midrst");
    check("midrst_pending", exp_q.size(), 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("midrst_mem8", mem[8], 8'd108);
    check("midrst_mem9", mem[9], 8'd75);
    check_ram("midrst_ram");

    // Clean full pass after reset.
    for (int k = 0; k < NB; k++) begin addr_tab[k] = AW'(15 - k % 16); data_tab[k] = DW'(k + 3); end
    build_expect(1'b0, NB);
    run_pass(1'b0, 1, 1'b0, NB, 1'b0);
    wait_done(NB);
    check("clean_mem15", mem[15], 8'd19);
    check("clean_mem0", mem[0], 8'd34);
    check_ram("clean_ram");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
